// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low {a,b,c,d,e,f,g} pattern constants
// (bit 6 = a), segment bit positions and the readback receiver FSM states.
package seg7_pkg;

  localparam int SEG_A_BIT = 6;
  localparam int SEG_B_BIT = 5;
  localparam int SEG_C_BIT = 4;
  localparam int SEG_D_BIT = 3;
  localparam int SEG_E_BIT = 2;
  localparam int SEG_F_BIT = 1;
  localparam int SEG_G_BIT = 0;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    ACCEPT,
    LOCKED
  } state_e;

endpackage

// File: rtl/seg7_lut.sv
// Combinational 7-segment pattern decoder: active-low pattern to {legal, blank, value}.
// With ALLOW_HEX=0 the A..F glyphs decode as illegal.
module seg7_lut #(
  parameter int ALLOW_HEX = 1
) (
  input  logic [6:0] pattern,
  output logic       legal,
  output logic       blank,
  output logic [3:0] value
);
  import seg7_pkg::*;

  logic       hit;
  logic [3:0] idx;

  // NOTE: every signal written here gets a default first, so no latch is inferred
  always_comb begin
    hit = 1'b1;
    idx = 4'h0;
    case (pattern)
      SEG_0:   idx = 4'h0;
      SEG_1:   idx = 4'h1;
      SEG_2:   idx = 4'h2;
      SEG_3:   idx = 4'h3;
      SEG_4:   idx = 4'h4;
      SEG_5:   idx = 4'h5;
      SEG_6:   idx = 4'h6;
      SEG_7:   idx = 4'h7;
      SEG_8:   idx = 4'h8;
      SEG_9:   idx = 4'h9;
      SEG_A:   idx = 4'hA;
      SEG_B:   idx = 4'hB;
      SEG_C:   idx = 4'hC;
      SEG_D:   idx = 4'hD;
      SEG_E:   idx = 4'hE;
      SEG_F:   idx = 4'hF;
      default: hit = 1'b0;
    endcase
    legal = hit && ((ALLOW_HEX != 0) || (idx < 4'hA));
    blank = (pattern == SEG_BLANK);
    value = legal ? idx : 4'h0;
  end

endmodule

// File: rtl/seg7_readback_rx.sv
// Readback decoder for an active-low 7-segment bus: synchronize, wait for a stable
// pattern, decode it. Build with SEG7_RX_ERRCNT_EN defined to get a saturating err_cnt.
module seg7_readback_rx #(
  parameter int STABLE_CYCLES = 4,
  parameter int ALLOW_HEX     = 1
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [6:0] seg_in,
  input  logic       en,
  output logic [3:0] digit,
  output logic       blank,
  output logic       valid,
  output logic       upd,
  output logic       err,
  output logic [7:0] err_cnt
);
  import seg7_pkg::*;

  localparam logic [7:0] STABLE_LIM = 8'(STABLE_CYCLES);
  // A single-sample filter accepts on the very sample that starts a candidate.
  localparam state_e LOAD_STATE = (STABLE_CYCLES == 1) ? ACCEPT : SETTLE;

  logic [6:0] sync1_q, sync1_d;
  logic [6:0] sync2_q, sync2_d;
  state_e     state_q, state_d;
  logic [6:0] cand_q, cand_d;
  logic [7:0] count_q, count_d;
  logic [3:0] digit_q, digit_d;
  logic       blank_q, blank_d;
  logic       valid_q, valid_d;
  logic       upd_q, upd_d;
  logic       err_q, err_d;
  logic [6:0] last_pat_q, last_pat_d;

  logic       lut_legal;
  logic       lut_blank;
  logic [3:0] lut_value;
  logic [7:0] count_inc;

  seg7_lut #(
    .ALLOW_HEX (ALLOW_HEX)
  ) u_lut (
    .pattern (cand_q),
    .legal   (lut_legal),
    .blank   (lut_blank),
    .value   (lut_value)
  );

  assign count_inc = count_q + 8'd1;

  always_comb begin
    sync1_d    = seg_in;
    sync2_d    = sync1_q;
    state_d    = state_q;
    cand_d     = cand_q;
    count_d    = count_q;
    digit_d    = digit_q;
    blank_d    = blank_q;
    valid_d    = valid_q;
    last_pat_d = last_pat_q;
    upd_d      = 1'b0;
    err_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (en) begin
          cand_d  = sync2_q;
          count_d = 8'd1;
          state_d = LOAD_STATE;
        end
      end

      SETTLE: begin
        if (en) begin
          if (sync2_q == cand_q) begin
            count_d = count_inc;
            if (count_inc == STABLE_LIM) state_d = ACCEPT;
          end else begin
            cand_d  = sync2_q;
            count_d = 8'd1;
            state_d = LOAD_STATE;
          end
        end
      end

      ACCEPT: begin
        state_d = LOCKED;
        if (lut_legal || lut_blank) begin
          // Re-accepting the same glyph after a rejected glitch is silent.
          upd_d      = !valid_q || (cand_q != last_pat_q);
          last_pat_d = cand_q;
          valid_d    = 1'b1;
          blank_d    = lut_blank;
          if (lut_legal) digit_d = lut_value;
        end else begin
          err_d = 1'b1;
        end
      end

      LOCKED: begin
        if (en && (sync2_q != cand_q)) begin
          cand_d  = sync2_q;
          count_d = 8'd1;
          state_d = LOAD_STATE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values
  always_ff @(posedge clk) begin
    if (clr) begin
      sync1_q    <= SEG_BLANK;
      sync2_q    <= SEG_BLANK;
      state_q    <= IDLE;
      cand_q     <= SEG_BLANK;
      count_q    <= 8'd0;
      digit_q    <= 4'h0;
      blank_q    <= 1'b0;
      valid_q    <= 1'b0;
      upd_q      <= 1'b0;
      err_q      <= 1'b0;
      last_pat_q <= SEG_BLANK;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      state_q    <= state_d;
      cand_q     <= cand_d;
      count_q    <= count_d;
      digit_q    <= digit_d;
      blank_q    <= blank_d;
      valid_q    <= valid_d;
      upd_q      <= upd_d;
      err_q      <= err_d;
      last_pat_q <= last_pat_d;
    end
  end

`ifdef SEG7_RX_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (clr) err_cnt_q <= 8'h00;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 8'h00;
`endif

  assign digit = digit_q;
  assign blank = blank_q;
  assign valid = valid_q;
  assign upd   = upd_q;
  assign err   = err_q;

endmodule

// File: tb/tb_seg7_readback_rx.sv
// Scoreboard bench for seg7_readback_rx: a hex and a no-hex instance share one input
// stream; a run-length reference model predicts every upd/err strobe and the held outputs.
`timescale 1ns/1ps
module tb_seg7_readback_rx;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       en  = 1'b0;
  logic [6:0] seg_in = 7'h7F;

  logic [3:0] dig   [2];
  logic       blk   [2];
  logic       vld   [2];
  logic       upd_o [2];
  logic       err_o [2];
  logic [7:0] ecnt  [2];

  always #5 clk = ~clk;

  seg7_readback_rx #(.STABLE_CYCLES(N), .ALLOW_HEX(1)) dut_hex (
    .clk(clk), .clr(clr), .seg_in(seg_in), .en(en),
    .digit(dig[0]), .blank(blk[0]), .valid(vld[0]),
    .upd(upd_o[0]), .err(err_o[0]), .err_cnt(ecnt[0])
  );

  seg7_readback_rx #(.STABLE_CYCLES(N), .ALLOW_HEX(0)) dut_nohex (
    .clk(clk), .clr(clr), .seg_in(seg_in), .en(en),
    .digit(dig[1]), .blank(blk[1]), .valid(vld[1]),
    .upd(upd_o[1]), .err(err_o[1]), .err_cnt(ecnt[1])
  );

  typedef struct {
    int         edge_no;
    bit         is_err;
    logic [3:0] digit;
    bit         blank;
    bit         valid;
    logic [7:0] ecnt;
  } exp_t;

  exp_t q [2][$];

  int n_checks = 0;
  int n_fail   = 0;
  int edge_cnt = 0;

  logic [6:0] pat_tab [16];

  // Reference model state: input pipeline, current run of identical samples, pending acceptance.
  logic [6:0] m_s1 = 7'h7F, m_s2 = 7'h7F;
  bit         have_run = 0;
  logic [6:0] run_pat  = 7'h7F;
  int         run_len  = 0;
  bit         pending  = 0;
  logic [6:0] pend_pat = 7'h7F;
  bit         mv    [2] = '{0, 0};
  logic [3:0] md    [2] = '{4'h0, 4'h0};
  bit         mb    [2] = '{0, 0};
  logic [6:0] mlast [2] = '{7'h7F, 7'h7F};
  logic [7:0] mec   [2] = '{8'h00, 8'h00};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp_v, edge_cnt);
    end
  endtask

  function automatic void decode(input logic [6:0] p, input bit hex,
                                 output bit legal, output bit is_blank, output logic [3:0] val);
    legal    = 0;
    is_blank = (p == 7'b1111111);
    val      = 4'h0;
    for (int i = 0; i < 16; i++)
      if (pat_tab[i] == p && (hex || i < 10)) begin
        legal = 1;
        val   = 4'(i);
      end
  endfunction

  task automatic resolve(input int i, input logic [6:0] p);
    bit         legal, is_blank, changed;
    logic [3:0] val;
    exp_t       x;
    decode(p, (i == 0), legal, is_blank, val);
    if (legal || is_blank) begin
      changed  = !mv[i] || (p != mlast[i]);
      mv[i]    = 1;
      mlast[i] = p;
      mb[i]    = is_blank;
      if (legal) md[i] = val;
      if (changed) begin
        x.edge_no = edge_cnt; x.is_err = 0; x.digit = md[i];
        x.blank = mb[i]; x.valid = 1; x.ecnt = mec[i];
        q[i].push_back(x);
      end
    end else begin
`ifdef SEG7_RX_ERRCNT_EN
      if (mec[i] != 8'hFF) mec[i] = mec[i] + 8'd1;
`endif
      x.edge_no = edge_cnt; x.is_err = 1; x.digit = md[i];
      x.blank = mb[i]; x.valid = mv[i]; x.ecnt = mec[i];
      q[i].push_back(x);
    end
  endtask

  task automatic model_edge(input logic [6:0] seg, input logic e, input logic c);
    logic [6:0] s;
    bit         grew;
    if (c) begin
      m_s1 = 7'h7F; m_s2 = 7'h7F;
      have_run = 0; run_len = 0; pending = 0;
      for (int i = 0; i < 2; i++) begin
        mv[i] = 0; md[i] = 4'h0; mb[i] = 0; mec[i] = 8'h00;
      end
      return;
    end
    s    = m_s2;
    m_s2 = m_s1;
    m_s1 = seg;
    grew = 0;
    if (pending) begin
      // The acceptance cycle does not look at the sample.
      pending = 0;
      for (int i = 0; i < 2; i++) resolve(i, pend_pat);
    end else if (e) begin
      if (!have_run || s != run_pat) begin
        have_run = 1; run_pat = s; run_len = 1; grew = 1;
      end else if (run_len < N) begin
        run_len++; grew = 1;
      end
      if (grew && run_len == N) begin
        pending  = 1;
        pend_pat = s;
      end
    end
  endtask

  task automatic step(input logic [6:0] seg, input logic e, input logic c);
    seg_in = seg;
    en     = e;
    clr    = c;
    @(posedge clk);
    edge_cnt++;
    model_edge(seg, e, c);
    #1;
  endtask

  task automatic hold(input logic [6:0] seg, input logic e, input int cycles);
    for (int k = 0; k < cycles; k++) step(seg, e, 1'b0);
  endtask

  // Monitor: compares held outputs every cycle and pops the scoreboard on each strobe.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        check($sformatf("digit[%0d]", i), 32'(dig[i]), 32'(md[i]));
        check($sformatf("blank[%0d]", i), 32'(blk[i]), 32'(mb[i]));
        check($sformatf("valid[%0d]", i), 32'(vld[i]), 32'(mv[i]));
        check($sformatf("err_cnt[%0d]", i), 32'(ecnt[i]), 32'(mec[i]));
        if (upd_o[i] || err_o[i]) begin
          if (q[i].size() == 0) begin
            check($sformatf("unexpected strobe upd/err[%0d]", i), 32'({upd_o[i], err_o[i]}), 32'd0);
          end else begin
            x = q[i].pop_front();
            check($sformatf("strobe edge[%0d]", i), 32'(edge_cnt), 32'(x.edge_no));
            check($sformatf("upd[%0d]", i), 32'(upd_o[i]), 32'(!x.is_err));
            check($sformatf("err[%0d]", i), 32'(err_o[i]), 32'(x.is_err));
          end
        end else if (q[i].size() != 0 && q[i][0].edge_no <= edge_cnt) begin
          x = q[i].pop_front();
          check($sformatf("missing strobe upd/err[%0d]", i), 32'({upd_o[i], err_o[i]}),
                x.is_err ? 32'd1 : 32'd2);
        end
      end
    end
  end

  initial begin
    logic [6:0] seg;
    logic [7:0] ecnt_exp;
    int         r;
    int         len;
    pat_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    // Reset, then first acceptance of '0'.
    for (int k = 0; k < 3; k++) step(7'b0000001, 1'b1, 1'b1);
    check("reset valid", 32'(vld[0]), 32'd0);
    check("reset digit", 32'(dig[0]), 32'd0);
    hold(7'b0000001, 1'b1, 10);
    check("first digit", 32'(dig[0]), 32'd0);
    check("first valid", 32'(vld[0]), 32'd1);

    // Stepped digits 1..4.
    hold(7'b1001111, 1'b1, 10);
    hold(7'b0010010, 1'b1, 10);
    hold(7'b0000110, 1'b1, 10);
    hold(7'b1001100, 1'b1, 10);
    check("step digit 4", 32'(dig[0]), 32'd4);

    // Two-cycle glitch inside a held '3'.
    hold(7'b0000110, 1'b1, 10);
    hold(7'b0000000, 1'b1, 2);
    hold(7'b0000110, 1'b1, 10);
    check("glitch digit", 32'(dig[0]), 32'd3);

    // Illegal pattern.
    hold(7'b1111110, 1'b1, 10);
`ifdef SEG7_RX_ERRCNT_EN
    ecnt_exp = 8'd1;
`else
    ecnt_exp = 8'd0;
`endif
    check("illegal err_cnt", 32'(ecnt[0]), 32'(ecnt_exp));
    check("illegal digit", 32'(dig[0]), 32'd3);

    // Hex 'A': decoded by the hex instance, illegal for the other.
    hold(7'b0001000, 1'b1, 10);
    check("hex digit", 32'(dig[0]), 32'hA);
    check("nohex digit", 32'(dig[1]), 32'd3);

    // Disabled while the input changes, then re-enabled.
    hold(7'b0110000, 1'b0, 8);
    check("en=0 digit", 32'(dig[0]), 32'hA);
    hold(7'b0110000, 1'b1, 10);
    check("en=1 digit", 32'(dig[0]), 32'hE);

    // Clear in the middle of settling.
    hold(7'b0100100, 1'b1, 4);
    step(7'b0100100, 1'b1, 1'b1);
    check("mid-settle clr valid", 32'(vld[0]), 32'd0);
    check("mid-settle clr digit", 32'(dig[0]), 32'd0);
    check("mid-settle clr err_cnt", 32'(ecnt[0]), 32'd0);
    hold(7'b0100100, 1'b1, 10);

    // Blank display.
    hold(7'b1111111, 1'b1, 10);
    check("blank flag", 32'(blk[0]), 32'd1);

    // Randomized runs of legal, blank and arbitrary patterns with en dropouts.
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 5)      seg = pat_tab[$urandom_range(0, 15)];
      else if (r == 6) seg = 7'b1111111;
      else if (r == 7) seg = 7'($urandom);
      else             seg = seg_in;
      len = $urandom_range(1, 12);
      if ($urandom_range(0, 79) == 0) step(seg, 1'b1, 1'b1);
      for (int k = 0; k < len; k++) step(seg, ($urandom_range(0, 7) != 0), 1'b0);
    end

    hold(seg_in, 1'b1, 12);
    check("scoreboard[0] drained", 32'(q[0].size()), 32'd0);
    check("scoreboard[1] drained", 32'(q[1].size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_readback_rx.md
Name: seg7_readback_rx

Overview:
- Receive-side decoder for the 7-segment drive used by the lab state-display blocks.
- Samples a 7-bit active-low segment bus (a..g, bit 6 = a, bit 0 = g), waits until the pattern is stable, and decodes it back to a 4-bit digit.
- Flags blank displays and illegal patterns.
- Sits on the loopback/monitor path, so benches and on-board self-check logic can read what the display drivers are showing.

Parameters:
- STABLE_CYCLES, 4: consecutive identical synchronized samples required before a pattern is accepted. Legal range 1..255.
- ALLOW_HEX, 1: 1 = decode A..F; 0 = the A..F patterns are treated as illegal.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- clr  input  1  synchronous active-high reset.
- seg_in  input  7  segment bus {a,b,c,d,e,f,g}, active-low (0 = lit); asynchronous to clk.
- en  input  1  digit enable; when 0, samples are ignored and the filter holds its state.
- digit  output  4  last accepted digit value.
- blank  output  1  last accepted pattern was all-off (7'b1111111).
- valid  output  1  digit/blank hold an accepted pattern.
- upd  output  1  one-cycle strobe when an accepted pattern differs from the previous accepted one.
- err  output  1  one-cycle strobe when a stable but illegal pattern is accepted.
- err_cnt  output  8  illegal-pattern count; see Optional Feature.

Behaviour:
- Reset: clk and clr only; clr is synchronous and active-high. When clr=1 at a rising edge:
  - digit=0, blank=0, valid=0, upd=0, err=0, err_cnt=0.
  - Sync flops load 7'b1111111.
  - FSM goes to IDLE and the stability counter goes to 0.
  - clr takes priority over every other event, including mid-settle.
- Input path: two-flop synchronizer on seg_in. The sample s is the second flop output.
- FSM states and transitions:
  - IDLE: no reference pattern held.
    - With en=1: capture s as cand, set count=1, go to SETTLE. If STABLE_CYCLES==1, go straight to ACCEPT.
  - SETTLE:
    - en=0: hold count and state.
    - en=1 and s==cand: increment count; reaching STABLE_CYCLES goes to ACCEPT.
    - en=1 and s!=cand: reload cand=s, set count=1, stay in SETTLE.
  - ACCEPT: single cycle. Decode cand and update the outputs, then go to LOCKED.
  - LOCKED:
    - en=1 and s!=cand: reload cand, set count=1, go to SETTLE. valid stays 1 during re-settle.
    - Otherwise stay in LOCKED.
- Decode table (active-low patterns):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111.
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
  - Blank = 1111111.
- ACCEPT actions:
  - Legal digit: digit=value, blank=0, valid=1.
  - Blank: blank=1, valid=1, digit holds its previous value.
  - Illegal: err=1 for one cycle; digit, blank and valid are unchanged.
  - upd=1 only for a legal or blank pattern that differs from the previously accepted legal/blank pattern, or on the first acceptance after reset.
- Latency: seg_in change to upd = 2 (sync) + STABLE_CYCLES + 1 cycles, with en held at 1.
- Glitch rejection: any pattern shorter than STABLE_CYCLES samples never produces upd or err.
- Count width: 8 bits, never wraps. Saturation is reached only via STABLE_CYCLES, which is ≤255.

Optional Feature:
- Macro: SEG7_RX_ERRCNT_EN.
- Defined: err_cnt increments on every err strobe and saturates at 8'hFF. Cleared only by clr.
- Undefined: err_cnt is tied to 8'h00 and no counter flops are built. The err strobe is unaffected.

Decomposition:
- Shared package seg7_pkg holds:
  - The 16 digit pattern constants plus SEG_BLANK.
  - The FSM state enum {IDLE, SETTLE, ACCEPT, LOCKED}.
  - The segment bit-order constants.
- Sub-module seg7_lut: purely combinational 7-bit pattern to {legal, blank, value[3:0]}, with ALLOW_HEX passed through. The same LUT is reusable by the display encoders.

Test Plan:
- clr high 3 cycles, seg_in=0000001, en=1, STABLE_CYCLES=4 -> upd pulses exactly 7 cycles after clr falls; digit=0, valid=1.
- Step seg_in 1001111 -> 0010010 -> 0000110 -> 1001100, each held 10 cycles -> digit sequence 1,2,3,4; one upd per step; err never asserted.
- 2-cycle glitch to 0000000 in the middle of a held 0000110 -> no upd, no err; digit stays 3.
- seg_in=1111110 held 10 cycles -> exactly one err pulse; valid/digit unchanged; err_cnt=1 when SEG7_RX_ERRCNT_EN is defined, else 0.
- ALLOW_HEX=0 with seg_in=0001000 -> err pulse. ALLOW_HEX=1 with the same input -> digit=4'hA, upd=1.
- en=0 while seg_in changes, then en=1 -> no update while disabled; settling restarts when en returns; clr asserted mid-SETTLE returns all outputs to reset values the next cycle.
